// File: rtl/bus_arbiter.sv
// ============================================================================
//  Module   : bus_arbiter
//  Purpose  : Round-robin arbiter/sequencer driving the one-hot gate select
//             of the shared 16-bit datapath bus (PC, ALU, MARMUX, MDR).
//  Options  : BUS_ARB_TIMEOUT_EN - revoke a grant after MAX_HOLD cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] req,
    output logic [3:0] select_1hot,
    output logic       bus_busy,
    output logic [1:0] owner_id,
    output logic       timeout_err
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] rr_q, rr_d;

    // Empty on legal values; an out-of-range MAX_HOLD elaborates nothing odd
    // but keeps the parameter referenced in builds without the timeout.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_out_of_range
    end

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       terr_q, terr_d;
`endif

    // Round-robin winner: first asserted request scanning upward from rr.
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        win   = rr_q;
        idx   = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_q + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        owner_d = owner_q;
        rr_d    = rr_q;
`ifdef BUS_ARB_TIMEOUT_EN
        hold_d  = hold_q;
        terr_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                sel_d  = 4'b0000;
                busy_d = 1'b0;
                if (|req) begin
                    state_d = S_GRANT;
                    sel_d   = 4'b0001 << win;
                    busy_d  = 1'b1;
                    owner_d = win;
`ifdef BUS_ARB_TIMEOUT_EN
                    hold_d  = 8'd1;
`endif
                end
            end
            S_GRANT: begin
                if (!req[owner_q]) begin
                    state_d = S_IDLE;
                    sel_d   = 4'b0000;
                    busy_d  = 1'b0;
                    rr_d    = owner_q + 2'd1;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (hold_q >= 8'(MAX_HOLD)) begin
                    state_d = S_IDLE;
                    sel_d   = 4'b0000;
                    busy_d  = 1'b0;
                    rr_d    = owner_q + 2'd1;
                    terr_d  = 1'b1;
                end else begin
                    hold_d  = hold_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            sel_q   <= 4'b0000;
            busy_q  <= 1'b0;
            owner_q <= 2'd0;
            rr_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_q <= 8'd0;
            terr_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign select_1hot = sel_q;
    assign bus_busy    = busy_q;
    assign owner_id    = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
//  Module   : tb_bus_arbiter
//  Purpose  : Directed, table-driven self-checking bench for bus_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] req;
    logic [3:0] select_1hot;
    logic       bus_busy;
    logic [1:0] owner_id;
    logic       timeout_err;

    int n_checks = 0;
    int n_pass   = 0;
    bit started  = 1'b0;

    bus_arbiter #(.MAX_HOLD(4)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .req         (req),
        .select_1hot (select_1hot),
        .bus_busy    (bus_busy),
        .owner_id    (owner_id),
        .timeout_err (timeout_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] sel;
        logic       busy;
        logic [1:0] own;
        logic       terr;
    } vec_t;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // select must be zero or one-hot on every cycle, and bus_busy must follow it.
    always @(negedge Clk) begin
        if (started) begin
            n_checks++;
            assert ($onehot0(select_1hot) && (bus_busy == |select_1hot)) n_pass++;
            else $display("FAIL onehot_invariant: select=%b busy=%b at %0t",
                          select_1hot, bus_busy, $time);
        end
    end

    vec_t vecs[41];

    initial begin
        //            rst   req      sel      busy  own   terr
        vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[3]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[4]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0};
        vecs[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0};
        vecs[7]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        // all four requesting, each owner releases after 3 grant cycles
        vecs[8]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[9]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[10] = '{1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[11] = '{1'b0, 4'b1110, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[12] = '{1'b0, 4'b1111, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[13] = '{1'b0, 4'b1111, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[14] = '{1'b0, 4'b1111, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[15] = '{1'b0, 4'b1101, 4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[16] = '{1'b0, 4'b1111, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[17] = '{1'b0, 4'b1111, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[18] = '{1'b0, 4'b1111, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[19] = '{1'b0, 4'b1011, 4'b0000, 1'b0, 2'd2, 1'b0};
        vecs[20] = '{1'b0, 4'b1111, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[21] = '{1'b0, 4'b1111, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[22] = '{1'b0, 4'b1111, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[23] = '{1'b0, 4'b0111, 4'b0000, 1'b0, 2'd3, 1'b0};
        vecs[24] = '{1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 1'b0};
        // ALU owns; PC and MDR arrive mid-grant, MDR wins next (scan 2,3,0)
        vecs[25] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[26] = '{1'b0, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[27] = '{1'b0, 4'b1011, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[28] = '{1'b0, 4'b1011, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[29] = '{1'b0, 4'b1001, 4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[30] = '{1'b0, 4'b1001, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[31] = '{1'b0, 4'b0001, 4'b0000, 1'b0, 2'd3, 1'b0};
        // one-cycle grant: PC drops on its grant cycle
        vecs[32] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[33] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        // reset on PC grant cycle 2; rr was 1, must return to 0
        vecs[34] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[35] = '{1'b1, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[36] = '{1'b0, 4'b0011, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[37] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        // single-cycle pulse in IDLE is still arbitrated
        vecs[38] = '{1'b0, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[39] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0};
        vecs[40] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0};

        Reset = 1'b1;
        req   = 4'b0000;

        for (int v = 0; v < 41; v++) begin
            @(negedge Clk);
            Reset = vecs[v].rst;
            req   = vecs[v].req;
            @(posedge Clk);
            #1;
            started = 1'b1;
            check($sformatf("v%0d_select", v), select_1hot, vecs[v].sel);
            check($sformatf("v%0d_busy", v), {3'b0, bus_busy}, {3'b0, vecs[v].busy});
            check($sformatf("v%0d_owner", v), {2'b0, owner_id}, {2'b0, vecs[v].own});
            check($sformatf("v%0d_timeout", v), {3'b0, timeout_err}, {3'b0, vecs[v].terr});
        end

        // MDR holds req for 10 cycles; with the timeout every 5th cycle is a
        // revocation gap, without it the grant is continuous.
        for (int k = 1; k <= 10; k++) begin
            logic [3:0] e_sel;
            logic       e_terr;
            @(negedge Clk);
            Reset = 1'b0;
            req   = 4'b1000;
            @(posedge Clk);
            #1;
`ifdef BUS_ARB_TIMEOUT_EN
            e_sel  = (k % 5 == 0) ? 4'b0000 : 4'b1000;
            e_terr = (k % 5 == 0);
`else
            e_sel  = 4'b1000;
            e_terr = 1'b0;
`endif
            check($sformatf("hold%0d_select", k), select_1hot, e_sel);
            check($sformatf("hold%0d_timeout", k), {3'b0, timeout_err}, {3'b0, e_terr});
            check($sformatf("hold%0d_owner", k), {2'b0, owner_id}, 4'd3);
        end
        @(negedge Clk);
        req = 4'b0000;
        @(posedge Clk);
        #1;
        check("hold_release_select", select_1hot, 4'b0000);
        check("hold_release_timeout", {3'b0, timeout_err}, 4'b0000);

        @(negedge Clk);
        started = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
